noc_traffic_monitor: RTL and testbench
======================================

// Module: noc_traffic_monitor
// PURPOSE
//   Synthesizable receive-side traffic monitor for the HNoC, parametrised in PE count and counter widths.
//   Taps the NoC->PE output handshakes of all NUM_PE ports and counts delivered packets.
//   Measures elapsed cycles from the first delivery to the delivery that reaches a programmable target.
//   Sits beside HNoC in hardware builds; exposes totals and a done flag for throughput = pkts/cycles.
// PARAMETERS
//   NUM_PE   8                       number of monitored PE ports (>=2)
//   DATA_W   32                      payload width per port
//   ADDR_W   $clog2(NUM_PE)          destination address width per port
//   CNT_W    32                      packet counter / target width
//   CYC_W    32                      elapsed-cycle counter width
// PORTS
//   i_clk            in   1                      clock
//   i_reset_n        in   1                      asynchronous active-low reset
//   i_clear          in   1                      sync clear: counters to 0, FSM to IDLE
//   i_enable         in   1                      arm request (sampled in IDLE only)
//   i_expected_pkts  in   CNT_W                  target count, captured on IDLE->ARMED
//   i_rx_data        in   NUM_PE*(DATA_W+ADDR_W) port k data at [k*(DATA_W+ADDR_W) +: DATA_W+ADDR_W]
//   i_rx_valid       in   NUM_PE                 NoC->PE valid, bit k = port k
//   i_rx_ready       in   NUM_PE                 PE->NoC ready, bit k = port k
//   o_total_pkts     out  CNT_W                  packets counted since arm
//   o_cycles         out  CYC_W                  elapsed cycles, first delivery..target delivery inclusive
//   o_running        out  1                      1 in ARMED or RUN
//   o_done           out  1                      1 in DONE
//   o_dest_err       out  1                      sticky address mismatch (DEST_CHECK_EN only)
//   o_dest_err_ch    out  ADDR_W                 port of first mismatch (DEST_CHECK_EN only)
// BEHAVIOUR
//   Reset (async, i_reset_n=0): FSM=IDLE; all outputs 0; captured target 0.
//   Delivery on port k in a cycle: i_rx_valid[k] & i_rx_ready[k]; hs_cnt = popcount over ports (0..NUM_PE).
//   FSM (registered, one transition per cycle; i_clear has priority in every state -> IDLE, counters 0):
//     IDLE : i_enable=1 -> capture i_expected_pkts; target==0 -> DONE (cycles=0), else ARMED.
//            Deliveries in IDLE are ignored.
//     ARMED: hs_cnt==0 -> stay. hs_cnt>0 -> total+=hs_cnt, cycles=1; total>=target -> DONE, else RUN.
//     RUN  : cycles+=1 every cycle; total+=hs_cnt; new total>=target -> DONE (same edge).
//     DONE : counters frozen; deliveries ignored; leave only via i_clear or reset; i_enable ignored.
//   Outputs are registered: updated count/state visible the cycle after the delivery edge (latency 1).
//   Overshoot allowed: several ports completing in the target cycle may leave total > target.
//   Both counters saturate at all-ones (no wrap); saturation of o_total_pkts forces DONE.
//   Reset or i_clear mid-run discards all counts; no partial result is retained.
//   Address field = upper ADDR_W bits of each port lane; payload = lower DATA_W bits (not inspected).
// CONFIGURATION
//   DEST_CHECK_EN defined: on any delivery in ARMED/RUN where port k address != k, set o_dest_err
//     (sticky until i_clear/reset) and load o_dest_err_ch with the lowest mismatching k of the
//     first erroring cycle; later errors leave o_dest_err_ch unchanged. Packet still counted.
//   DEST_CHECK_EN undefined: no comparators built; o_dest_err and o_dest_err_ch tied to 0.
// TESTING
//   1 Reset held, valid/ready all 1 -> all outputs 0; release, no i_enable -> counts stay 0.
//   2 NUM_PE=8, target=800, arm, all 8 ports deliver every cycle from cycle 5 -> done after 100
//     delivery cycles, o_total_pkts=800, o_cycles=100, o_running falls as o_done rises.
//   3 target=10, 3 ports deliver per cycle -> DONE on 4th delivery cycle, total=12, cycles=4;
//     further deliveries leave 12/4 unchanged.
//   4 target=0 with i_enable -> o_done=1 next cycle, total=0, cycles=0; i_clear -> IDLE, all 0.
//   5 RUN with total=5, assert i_clear and i_enable together -> IDLE, counters 0; re-arm counts afresh.
//   6 DEST_CHECK_EN: port 3 delivers addr 5, then port 1 delivers addr 0 -> o_dest_err=1,
//     o_dest_err_ch=3, both packets counted; without macro o_dest_err stays 0.

Source files
------------

// File: rtl/noc_traffic_monitor.sv
// Receive-side HNoC traffic monitor: counts NoC->PE deliveries and the cycles from first delivery to the target.
// Optional destination-address checking is enabled with the DEST_CHECK_EN macro.
module noc_traffic_monitor #(
  parameter int NUM_PE = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = $clog2(NUM_PE),
  parameter int CNT_W  = 32,
  parameter int CYC_W  = 32
) (
  input  logic                               i_clk,
  input  logic                               i_reset_n,
  input  logic                               i_clear,
  input  logic                               i_enable,
  input  logic [CNT_W-1:0]                   i_expected_pkts,
  input  logic [NUM_PE*(DATA_W+ADDR_W)-1:0]  i_rx_data,
  input  logic [NUM_PE-1:0]                  i_rx_valid,
  input  logic [NUM_PE-1:0]                  i_rx_ready,
  output logic [CNT_W-1:0]                   o_total_pkts,
  output logic [CYC_W-1:0]                   o_cycles,
  output logic                               o_running,
  output logic                               o_done,
  output logic                               o_dest_err,
  output logic [ADDR_W-1:0]                  o_dest_err_ch
);

  localparam int LANE_W = DATA_W + ADDR_W;
  localparam int HS_W   = $clog2(NUM_PE + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] target_q, target_d;

  logic [NUM_PE-1:0] hs;
  logic [HS_W-1:0]   hs_cnt;
  logic [CNT_W:0]    sum;
  logic [CNT_W-1:0]  total_sat;
  logic [CYC_W-1:0]  cyc_inc;

  // Payload bits are never inspected; reduce them so the whole bus is consumed.
  logic unused_rx_data;
  assign unused_rx_data = ^i_rx_data;

  always_comb begin
    hs     = i_rx_valid & i_rx_ready;
    hs_cnt = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      hs_cnt = hs_cnt + HS_W'(hs[k]);
    end
    sum       = {1'b0, total_q} + (CNT_W+1)'(hs_cnt);
    total_sat = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    cyc_inc   = (&cycles_q) ? cycles_q : cycles_q + CYC_W'(1);
  end

  // A saturated total is all-ones, which is >= any target, so saturation ends the run too.
  always_comb begin
    state_d  = state_q;
    total_d  = total_q;
    cycles_d = cycles_q;
    target_d = target_q;
    if (i_clear) begin
      state_d  = ST_IDLE;
      total_d  = '0;
      cycles_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_enable) begin
            target_d = i_expected_pkts;
            total_d  = '0;
            cycles_d = '0;
            state_d  = (i_expected_pkts == '0) ? ST_DONE : ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (hs_cnt != '0) begin
            total_d  = total_sat;
            cycles_d = CYC_W'(1);
            state_d  = (total_sat >= target_q) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          total_d  = total_sat;
          cycles_d = cyc_inc;
          if (total_sat >= target_q) state_d = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      total_q  <= '0;
      cycles_q <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      cycles_q <= cycles_d;
      target_q <= target_d;
    end
  end

  assign o_total_pkts = total_q;
  assign o_cycles     = cycles_q;
  assign o_running    = (state_q == ST_ARMED) || (state_q == ST_RUN);
  assign o_done       = (state_q == ST_DONE);

`ifdef DEST_CHECK_EN
  logic [NUM_PE-1:0] mism;
  logic [ADDR_W-1:0] first_ch;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] ch_q, ch_d;

  always_comb begin
    mism     = '0;
    first_ch = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      mism[k] = hs[k] && (i_rx_data[k*LANE_W+DATA_W +: ADDR_W] != ADDR_W'(k));
    end
    for (int k = NUM_PE - 1; k >= 0; k--) begin
      if (mism[k]) first_ch = ADDR_W'(k);
    end
  end

  always_comb begin
    err_d = err_q;
    ch_d  = ch_q;
    if (i_clear) begin
      err_d = 1'b0;
      ch_d  = '0;
    end else if (o_running && (|mism) && !err_q) begin
      err_d = 1'b1;
      ch_d  = first_ch;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      err_q <= 1'b0;
      ch_q  <= '0;
    end else begin
      err_q <= err_d;
      ch_q  <= ch_d;
    end
  end

  assign o_dest_err    = err_q;
  assign o_dest_err_ch = ch_q;
`else
  assign o_dest_err    = 1'b0;
  assign o_dest_err_ch = '0;
`endif

endmodule

// File: tb/tb_noc_traffic_monitor.sv
// Bench for noc_traffic_monitor: vector table plus hand sequences, expectations queued per driven cycle.
module tb_noc_traffic_monitor;

  localparam int NUM_PE = 8;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int LANE_W = DATA_W + ADDR_W;
  localparam int DW     = NUM_PE * LANE_W;
`ifdef DEST_CHECK_EN
  localparam bit DC = 1'b1;
`else
  localparam bit DC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear, enable;
  logic [31:0]   expected;
  logic [DW-1:0] rx_data;
  logic [7:0]    rx_valid, rx_ready;
  logic [31:0]   total, cycles;
  logic          running, done, dest_err;
  logic [2:0]    dest_err_ch;

  noc_traffic_monitor dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear(clear), .i_enable(enable),
    .i_expected_pkts(expected), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_rx_ready(rx_ready), .o_total_pkts(total), .o_cycles(cycles),
    .o_running(running), .o_done(done), .o_dest_err(dest_err),
    .o_dest_err_ch(dest_err_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tot;
    logic [31:0] cyc;
    logic        run;
    logic        dn;
    logic        err;
    logic [2:0]  ch;
  } exp_t;

  typedef struct {
    logic        clr;
    logic        en;
    logic [31:0] tgt;
    logic [7:0]  vld;
    logic [7:0]  rdy;
    logic [31:0] tot;
    logic [31:0] cyc;
    logic        run;
    logic        dn;
  } vec_t;

  exp_t sb[$];
  vec_t vt[19];
  int   errors = 0;
  int   checks = 0;
  int   stepno = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %0d want %0d", nm, stepno, act, want);
    end
  endtask

  function automatic logic [DW-1:0] good_lanes();
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < NUM_PE; k++) d[k*LANE_W +: LANE_W] = {3'(k), 32'hC0DE0000 + 32'(k)};
    return d;
  endfunction

  task automatic step(input logic clr, input logic en, input logic [31:0] tgt,
                      input logic [7:0] vld, input logic [7:0] rdy,
                      input logic [DW-1:0] dat, input exp_t e);
    exp_t got;
    clear = clr; enable = en; expected = tgt;
    rx_valid = vld; rx_ready = rdy; rx_data = dat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    stepno++;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard step %0d: got empty queue want one entry", stepno);
    end else begin
      got = sb.pop_front();
      chk("total", total, got.tot);
      chk("cycles", cycles, got.cyc);
      chk("running", 32'(running), 32'(got.run));
      chk("done", 32'(done), 32'(got.dn));
      chk("dest_err", 32'(dest_err), 32'(got.err));
      chk("dest_err_ch", 32'(dest_err_ch), 32'(got.ch));
    end
  endtask

  function automatic exp_t mk(input logic [31:0] t, input logic [31:0] c, input logic r,
                              input logic d, input logic er, input logic [2:0] ch);
    exp_t e;
    e.tot = t; e.cyc = c; e.run = r; e.dn = d; e.err = er; e.ch = ch;
    return e;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d;
    // clr en tgt vld rdy | tot cyc run done
    vt[0]  = '{1'b1, 1'b0, 32'd0,   8'h00, 8'hFF, 32'd0,  32'd0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 32'd10,  8'h00, 8'hFF, 32'd0,  32'd0, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 32'd0,   8'h07, 8'hFF, 32'd3,  32'd1, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 32'd0,   8'h07, 8'hFF, 32'd6,  32'd2, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 32'd0,   8'h07, 8'hFF, 32'd9,  32'd3, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 32'd0,   8'h07, 8'hFF, 32'd12, 32'd4, 1'b0, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 32'd50,  8'hFF, 8'hFF, 32'd12, 32'd4, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 32'd0,   8'hFF, 8'hFF, 32'd12, 32'd4, 1'b0, 1'b1};
    vt[8]  = '{1'b1, 1'b0, 32'd0,   8'h00, 8'hFF, 32'd0,  32'd0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 32'd0,   8'h00, 8'hFF, 32'd0,  32'd0, 1'b0, 1'b1};
    vt[10] = '{1'b0, 1'b1, 32'd7,   8'hFF, 8'hFF, 32'd0,  32'd0, 1'b0, 1'b1};
    vt[11] = '{1'b1, 1'b0, 32'd0,   8'h00, 8'hFF, 32'd0,  32'd0, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b1, 32'd100, 8'hFF, 8'hFF, 32'd0,  32'd0, 1'b1, 1'b0};
    vt[13] = '{1'b0, 1'b0, 32'd0,   8'h1F, 8'hFF, 32'd5,  32'd1, 1'b1, 1'b0};
    vt[14] = '{1'b1, 1'b1, 32'd4,   8'hFF, 8'hFF, 32'd0,  32'd0, 1'b0, 1'b0};
    vt[15] = '{1'b0, 1'b1, 32'd4,   8'h00, 8'hFF, 32'd0,  32'd0, 1'b1, 1'b0};
    vt[16] = '{1'b0, 1'b0, 32'd0,   8'h03, 8'h01, 32'd1,  32'd1, 1'b1, 1'b0};
    vt[17] = '{1'b0, 1'b0, 32'd0,   8'h00, 8'h00, 32'd1,  32'd2, 1'b1, 1'b0};
    vt[18] = '{1'b0, 1'b0, 32'd0,   8'hFF, 8'hFF, 32'd9,  32'd3, 1'b0, 1'b1};

    d = good_lanes();

    // reset held with every port handshaking
    rst_n = 1'b0; clear = 1'b0; enable = 1'b1; expected = 32'd5;
    rx_valid = 8'hFF; rx_ready = 8'hFF; rx_data = d;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_total", total, 32'd0);
    chk("rst_cycles", cycles, 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dest_err", 32'(dest_err), 32'd0);
    chk("rst_dest_err_ch", 32'(dest_err_ch), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd5, 8'hFF, 8'hFF, d, mk(0, 0, 0, 0, 0, 0));

    // full-rate run to 800 packets
    step(1'b0, 1'b1, 32'd800, 8'h00, 8'hFF, d, mk(0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 8'h00, 8'hFF, d, mk(0, 0, 1, 0, 0, 0));
    for (int n = 1; n <= 100; n++)
      step(1'b0, 1'b0, 32'd0, 8'hFF, 8'hFF, d,
           mk(32'(8 * n), 32'(n), (n < 100), (n == 100), 0, 0));
    step(1'b0, 1'b0, 32'd0, 8'hFF, 8'hFF, d, mk(800, 100, 0, 1, 0, 0));

    // vector table
    for (int i = 0; i < 19; i++)
      step(vt[i].clr, vt[i].en, vt[i].tgt, vt[i].vld, vt[i].rdy, d,
           mk(vt[i].tot, vt[i].cyc, vt[i].run, vt[i].dn, 0, 0));

    // destination mismatches: port 3 carries addr 5, then port 1 addr 0, then port 0 addr 7
    step(1'b1, 1'b0, 32'd0, 8'h00, 8'hFF, d, mk(0, 0, 0, 0, 0, 0));
    step(1'b0, 1'b1, 32'd100, 8'h00, 8'hFF, d, mk(0, 0, 1, 0, 0, 0));
    d[3*LANE_W+DATA_W +: ADDR_W] = 3'd5;
    step(1'b0, 1'b0, 32'd0, 8'h08, 8'hFF, d, mk(1, 1, 1, 0, DC, DC ? 3'd3 : 3'd0));
    d[1*LANE_W+DATA_W +: ADDR_W] = 3'd0;
    step(1'b0, 1'b0, 32'd0, 8'h02, 8'hFF, d, mk(2, 2, 1, 0, DC, DC ? 3'd3 : 3'd0));
    d[0*LANE_W+DATA_W +: ADDR_W] = 3'd7;
    step(1'b0, 1'b0, 32'd0, 8'h01, 8'hFF, d, mk(3, 3, 1, 0, DC, DC ? 3'd3 : 3'd0));
    step(1'b1, 1'b0, 32'd0, 8'h00, 8'hFF, d, mk(0, 0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
